// File: rtl/div_sequencer.sv
// Sequences a multi-cycle divider for the EX stage: latches operands, holds the pipeline,
// captures {remainder, quotient} into HI/LO, and quiesces the divider after a flush.
module div_sequencer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CANCEL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  div_req_i,
  input  logic                  div_signed_i,
  input  logic [DATA_W-1:0]     div_op1_i,
  input  logic [DATA_W-1:0]     div_op2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  dv_start_o,
  output logic                  dv_annul_o,
  output logic                  dv_signed_o,
  output logic [DATA_W-1:0]     dv_op1_o,
  output logic [DATA_W-1:0]     dv_op2_o,
  input  logic [2*DATA_W-1:0]   dv_result_i,
  input  logic                  dv_ready_i,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  hilo_we_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StCancel} state_e;

  localparam logic [2:0] CntLoad = 3'(CANCEL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              signed_q, signed_d;
  logic              we_q, we_d;
  logic              req_ok;

  assign req_ok = div_req_i & ~flush_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    stall_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          op1_d    = div_op1_i;
          op2_d    = div_op2_i;
          signed_d = div_signed_i;
          stall_o  = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // A flush wins even in the cycle the divider reports ready.
        if (flush_i) begin
          stall_o = 1'b1;
          cnt_d   = CntLoad;
          state_d = StCancel;
        end else if (dv_ready_i) begin
          hi_d    = dv_result_i[2*DATA_W-1:DATA_W];
          lo_d    = dv_result_i[DATA_W-1:0];
          we_d    = 1'b1;
          state_d = StDrain;
        end else begin
          stall_o = 1'b1;
        end
      end
      StDrain: begin
        stall_o = req_ok;
        state_d = StIdle;
      end
      StCancel: begin
        stall_o = req_ok;
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
    end
  end

  // Start/annul decode straight from state so reset clears them without a clock.
  assign dv_start_o  = (state_q == StBusy);
  assign dv_annul_o  = (state_q == StCancel);
  assign dv_signed_o = signed_q;
  assign dv_op1_o    = op1_q;
  assign dv_op2_o    = op2_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign hilo_we_o   = we_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer; the bench plays the divider and checks HI/LO
// against plain arithmetic division.
module tb_div_sequencer;

  localparam int CC = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_req_i, div_signed_i, flush_i, dv_ready_i;
  logic [31:0] div_op1_i, div_op2_i;
  logic [63:0] dv_result_i;
  logic        stall_o, dv_start_o, dv_annul_o, dv_signed_o, hilo_we_o;
  logic [31:0] dv_op1_o, dv_op2_o, hi_o, lo_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_sequencer #(.DATA_W(32), .CANCEL_CYCLES(CC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .div_req_i   (div_req_i),
    .div_signed_i(div_signed_i),
    .div_op1_i   (div_op1_i),
    .div_op2_i   (div_op2_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .dv_start_o  (dv_start_o),
    .dv_annul_o  (dv_annul_o),
    .dv_signed_o (dv_signed_o),
    .dv_op1_o    (dv_op1_o),
    .dv_op2_o    (dv_op2_o),
    .dv_result_i (dv_result_i),
    .dv_ready_i  (dv_ready_i),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .hilo_we_o   (hilo_we_o)
  );

  always #5 clk = ~clk;

  // Reference divider: {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int          sa, sb, sq, sr;
    logic [31:0] q, r;
    if (s) begin
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      q  = sq;
      r  = sr;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full divide from IDLE: accept, lat not-ready cycles, ready, DRAIN, back to IDLE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat);
    logic [63:0] r;
    r = ref_div(a, b, s);
    div_req_i = 1'b1; div_signed_i = s; div_op1_i = a; div_op2_i = b;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL idle_accept_stall: got %b want 1", stall_o);
    end
    step();
    // Live EX inputs wander; the latched copies must not follow them.
    div_signed_i = ~s; div_op1_i = $urandom; div_op2_i = $urandom;
    for (int i = 0; i < lat; i++) begin
      #1;
      checks++;
      if ({dv_start_o, dv_annul_o, stall_o, hilo_we_o} !== 4'b1010 || dv_op1_o !== a ||
          dv_op2_o !== b || dv_signed_o !== s) begin
        errors++;
        $display("FAIL busy_wait: st/an/stl/we=%b%b%b%b op1=%h op2=%h sg=%b want 1010 %h %h %b",
                 dv_start_o, dv_annul_o, stall_o, hilo_we_o, dv_op1_o, dv_op2_o, dv_signed_o,
                 a, b, s);
      end
      step();
    end
    dv_ready_i = 1'b1; dv_result_i = r;
    #1;
    checks++;
    if ({dv_start_o, stall_o, hilo_we_o} !== 3'b100 || dv_op1_o !== a || dv_signed_o !== s)
    begin
      errors++;
      $display("FAIL ready_cycle: st/stl/we=%b%b%b op1=%h sg=%b want 100 %h %b",
               dv_start_o, stall_o, hilo_we_o, dv_op1_o, dv_signed_o, a, s);
    end
    step();
    dv_ready_i = 1'b0; div_req_i = 1'b0; dv_result_i = {$urandom, $urandom};
    exp_hi = r[63:32]; exp_lo = r[31:0];
    #1;
    checks++;
    if ({dv_start_o, dv_annul_o, hilo_we_o} !== 3'b001 || hi_o !== exp_hi || lo_o !== exp_lo)
    begin
      errors++;
      $display("FAIL drain_write: st/an/we=%b%b%b hi=%h lo=%h want 001 %h %h",
               dv_start_o, dv_annul_o, hilo_we_o, hi_o, lo_o, exp_hi, exp_lo);
    end
    step();
    checks++;
    if ({dv_start_o, dv_annul_o, stall_o, hilo_we_o} !== 4'b0000 || hi_o !== exp_hi) begin
      errors++;
      $display("FAIL back_idle: st/an/stl/we=%b%b%b%b hi=%h want 0000 %h",
               dv_start_o, dv_annul_o, stall_o, hilo_we_o, hi_o, exp_hi);
    end
  endtask

  // Walk CC cycles of CANCEL, probing stall with and without a concurrent flush.
  task automatic check_cancel(input string tag);
    for (int i = 0; i < CC; i++) begin
      div_req_i = 1'b1; flush_i = (i == 0);
      #1;
      checks++;
      if ({dv_start_o, dv_annul_o, hilo_we_o} !== 3'b010 || stall_o !== (i != 0) ||
          hi_o !== exp_hi || lo_o !== exp_lo) begin
        errors++;
        $display("FAIL %s_cancel%0d: st/an/we=%b%b%b stl=%b hi=%h lo=%h want 010 %b %h %h",
                 tag, i, dv_start_o, dv_annul_o, hilo_we_o, stall_o, hi_o, lo_o, i != 0,
                 exp_hi, exp_lo);
      end
      div_req_i = 1'b0; flush_i = 1'b0;
      step();
    end
    checks++;
    if ({dv_start_o, dv_annul_o, hilo_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL %s_cancel_exit: st/an/we=%b%b%b want 000", tag, dv_start_o, dv_annul_o,
               hilo_we_o);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; div_req_i = 0; div_signed_i = 0; flush_i = 0; dv_ready_i = 0;
    div_op1_i = '0; div_op2_i = '0; dv_result_i = '0;
    #2;
    checks++;
    if ({stall_o, dv_start_o, dv_annul_o, dv_signed_o, hilo_we_o} !== 5'b0 ||
        {hi_o, lo_o, dv_op1_o, dv_op2_o} !== 128'b0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b%b%b%b%b hi=%h lo=%h op1=%h op2=%h want all 0",
               stall_o, dv_start_o, dv_annul_o, dv_signed_o, hilo_we_o, hi_o, lo_o,
               dv_op1_o, dv_op2_o);
    end
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_signed();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 3);
    checks++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL signed_m7_2: hi=%h lo=%h want ffffffff fffffffd", hi_o, lo_o);
    end
  endtask

  task automatic test_unsigned();
    do_div(32'd100, 32'd7, 1'b0, 2);
    checks++;
    if (hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++; $display("FAIL unsigned_100_7: hi=%0d lo=%0d want 2 14", hi_o, lo_o);
    end
  endtask

  task automatic test_flush();
    div_req_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd50; div_op2_i = 32'd5;
    step();
    for (int i = 0; i < 5; i++) step();
    flush_i = 1'b1; div_req_i = 1'b0;
    #1;
    checks++;
    if ({dv_start_o, stall_o} !== 2'b11) begin
      errors++; $display("FAIL flush_busy: st/stl=%b%b want 11", dv_start_o, stall_o);
    end
    step();
    flush_i = 1'b0;
    check_cancel("flush");
    do_div($urandom, $urandom_range(1, 1000), 1'b0, 4);
  endtask

  task automatic test_ready_flush();
    div_req_i = 1'b1; div_signed_i = 1'b1; div_op1_i = 32'd77; div_op2_i = 32'd4;
    step(); step();
    dv_ready_i = 1'b1; dv_result_i = {32'd1, 32'd19}; flush_i = 1'b1; div_req_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL ready_flush_stall: got %b want 1", stall_o);
    end
    step();
    dv_ready_i = 1'b0; flush_i = 1'b0;
    check_cancel("ready_flush");
  endtask

  task automatic test_div_zero();
    div_req_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd5; div_op2_i = 32'd0;
    step();
    step();
    // By-zero ends early on the divider side; the flush must still win.
    flush_i = 1'b1; div_req_i = 1'b0; dv_ready_i = 1'b1; dv_result_i = {32'd5, 32'hFFFF_FFFF};
    step();
    flush_i = 1'b0; dv_ready_i = 1'b0;
    check_cancel("divzero");
    do_div(32'd9, 32'd3, 1'b0, 1);
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd3) begin
      errors++; $display("FAIL after_divzero_9_3: hi=%0d lo=%0d want 0 3", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_busy();
    div_req_i = 1'b1; div_signed_i = 1'b1; div_op1_i = 32'h1234_5678; div_op2_i = 32'd3;
    step(); step(); step();
    resetn = 1'b0;
    #1;
    checks++;
    if ({dv_start_o, dv_annul_o, dv_signed_o, hilo_we_o} !== 4'b0 ||
        {hi_o, lo_o, dv_op1_o, dv_op2_o} !== 128'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: ctl=%b%b%b%b hi=%h lo=%h op1=%h op2=%h want all 0",
               dv_start_o, dv_annul_o, dv_signed_o, hilo_we_o, hi_o, lo_o, dv_op1_o, dv_op2_o);
    end
    exp_hi = '0; exp_lo = '0;
    step();
    resetn = 1'b1;
    div_signed_i = 1'b0; div_op1_i = 32'd1000; div_op2_i = 32'd9;
    step();
    checks++;
    if (dv_start_o !== 1'b1 || dv_op1_o !== 32'd1000 || hilo_we_o !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_reset: st=%b op1=%0d we=%b want 1 1000 0", dv_start_o,
               dv_op1_o, hilo_we_o);
    end
    dv_ready_i = 1'b1; dv_result_i = ref_div(32'd1000, 32'd9, 1'b0);
    step();
    dv_ready_i = 1'b0; div_req_i = 1'b0;
    checks++;
    if (hilo_we_o !== 1'b1 || hi_o !== 32'd1 || lo_o !== 32'd111) begin
      errors++;
      $display("FAIL post_reset_div: we=%b hi=%0d lo=%0d want 1 1 111", hilo_we_o, hi_o, lo_o);
    end
    exp_hi = 32'd1; exp_lo = 32'd111;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] b1, b2;
    b1 = $urandom; b2 = $urandom_range(1, 255);
    div_req_i = 1'b1; div_signed_i = 1'b0; div_op1_i = 32'd81; div_op2_i = 32'd8;
    step();
    dv_ready_i = 1'b1; dv_result_i = ref_div(32'd81, 32'd8, 1'b0);
    step();
    // Next instruction is another divide and arrives in EX during DRAIN.
    dv_ready_i = 1'b0; div_op1_i = b1; div_op2_i = b2;
    #1;
    checks++;
    if ({dv_start_o, stall_o, hilo_we_o} !== 3'b011 || lo_o !== 32'd10 || hi_o !== 32'd1) begin
      errors++;
      $display("FAIL b2b_drain: st/stl/we=%b%b%b hi=%0d lo=%0d want 011 1 10", dv_start_o,
               stall_o, hilo_we_o, hi_o, lo_o);
    end
    step();
    checks++;
    if ({dv_start_o, stall_o, hilo_we_o} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_idle: st/stl/we=%b%b%b want 010", dv_start_o, stall_o, hilo_we_o);
    end
    step();
    checks++;
    if (dv_start_o !== 1'b1 || dv_op1_o !== b1 || dv_op2_o !== b2) begin
      errors++;
      $display("FAIL b2b_issue: st=%b op1=%h op2=%h want 1 %h %h", dv_start_o, dv_op1_o,
               dv_op2_o, b1, b2);
    end
    dv_ready_i = 1'b1; dv_result_i = ref_div(b1, b2, 1'b0);
    exp_hi = b1 % b2; exp_lo = b1 / b2;
    step();
    dv_ready_i = 1'b0; div_req_i = 1'b0;
    checks++;
    if (hilo_we_o !== 1'b1 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL b2b_result: we=%b hi=%h lo=%h want 1 %h %h", hilo_we_o, hi_o, lo_o,
               exp_hi, exp_lo);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    for (int n = 0; n < 20; n++) begin
      a = $urandom; b = $urandom; s = $urandom_range(0, 1);
      if (n % 4 == 0) b = $urandom_range(1, 16);
      if (b == 0) b = 32'd1;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      // A flushed request in IDLE must be ignored.
      div_req_i = 1'b1; flush_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
        errors++; $display("FAIL idle_flush_stall: got %b want 0", stall_o);
      end
      step();
      div_req_i = 1'b0; flush_i = 1'b0;
      checks++;
      if (dv_start_o !== 1'b0) begin
        errors++; $display("FAIL idle_flush_accept: st=%b want 0", dv_start_o);
      end
      do_div(a, b, s, $urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_flush();
    test_ready_flush();
    test_div_zero();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
